// File: rtl/deskew_ctrl.sv
// Lane deskew calibration controller: measures training-marker arrival skew
// per lane and applies compensating 0..3-cycle delay selects once the lanes are quiet.
module deskew_ctrl #(
  parameter int unsigned NLANE = 4,
  parameter int unsigned TMO   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NLANE-1:0]   lane_mark,
  input  logic [NLANE-1:0]   lane_act,
  output logic [2*NLANE-1:0] lane_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam int unsigned TW = 8;
  localparam int unsigned SW = 2 * NLANE;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  localparam logic [1:0] CODE_FIRST   = 2'b01;
  localparam logic [1:0] CODE_SKEW    = 2'b10;
  localparam logic [1:0] CODE_QUIESCE = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WAIT_FIRST, MEASURE, CHECK, QUIESCE, APPLY
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [1:0]      meas_q, meas_d;
  logic [1:0]      quiet_q, quiet_d;
  logic [NLANE-1:0] cap_q, cap_d;
  logic [SW-1:0]   arr_q, arr_d;
  logic [SW-1:0]   nsel_q, nsel_d;
  logic [SW-1:0]   sel_d;
  logic            busy_d, done_d, err_d;
  logic [1:0]      code_d;

  logic [NLANE-1:0] new_cap;
  logic             all_cap;
  logic [1:0]       arr_max;
  logic [1:0]       quiet_nx;

  // State and all outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      meas_q   <= '0;
      quiet_q  <= '0;
      cap_q    <= '0;
      arr_q    <= '0;
      nsel_q   <= '0;
      lane_sel <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      meas_q   <= meas_d;
      quiet_q  <= quiet_d;
      cap_q    <= cap_d;
      arr_q    <= arr_d;
      nsel_q   <= nsel_d;
      lane_sel <= sel_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      err_code <= code_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    meas_d   = meas_q;
    quiet_d  = quiet_q;
    cap_d    = cap_q;
    arr_d    = arr_q;
    nsel_d   = nsel_q;
    sel_d    = lane_sel;
    done_d   = 1'b0;
    err_d    = err;
    code_d   = err_code;
    new_cap  = lane_mark & ~cap_q;
    all_cap  = &(cap_q | new_cap);
    arr_max  = 2'd0;
    quiet_nx = 2'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_FIRST;
          err_d   = 1'b0;
          code_d  = 2'b00;
          cap_d   = '0;
          arr_d   = '0;
          tmo_d   = '0;
        end
      end

      WAIT_FIRST: begin
        if (lane_mark != '0) begin
          cap_d   = lane_mark;
          arr_d   = '0;
          meas_d  = 2'd1;
          state_d = (&lane_mark) ? CHECK : MEASURE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          code_d  = CODE_FIRST;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      MEASURE: begin
        // First mark per lane wins; repeats on captured lanes are masked
        for (int unsigned i = 0; i < NLANE; i++) begin
          if (new_cap[i]) arr_d[2*i +: 2] = meas_q;
        end
        cap_d = cap_q | new_cap;
        if (all_cap) begin
          state_d = CHECK;
        end else if (meas_q == 2'd3) begin
          err_d   = 1'b1;
          code_d  = CODE_SKEW;
          state_d = IDLE;
        end else begin
          meas_d = meas_q + 2'd1;
        end
      end

      CHECK: begin
        for (int unsigned i = 0; i < NLANE; i++) begin
          if (arr_q[2*i +: 2] > arr_max) arr_max = arr_q[2*i +: 2];
        end
        for (int unsigned i = 0; i < NLANE; i++) begin
          nsel_d[2*i +: 2] = arr_max - arr_q[2*i +: 2];
        end
        quiet_d = 2'd0;
        tmo_d   = '0;
        state_d = QUIESCE;
      end

      QUIESCE: begin
        // Selects may only change once no pulse can be in flight in any delay line
        if (lane_act != '0)        quiet_nx = 2'd0;
        else if (quiet_q == 2'd3)  quiet_nx = 2'd3;
        else                       quiet_nx = quiet_q + 2'd1;
        quiet_d = quiet_nx;
        if (quiet_nx == 2'd3) begin
          state_d = APPLY;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          code_d  = CODE_QUIESCE;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      APPLY: begin
        sel_d   = nsel_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
